// File: rtl/vec_alu_pipe.sv
// vec_alu_pipe: N-lane vector execute unit between ID/EXE and EX/MEM.
// Element-wise ops (ADD, SUB, AND, OR, SLT, SADD) complete in one cycle.
// MUL (iterative shift-add, DW cycles) and RSUM (adder tree, LOG2L cycles)
// are multi-cycle. Valid/ready on both sides, per-lane write masks, and a
// synchronous flush for branch squash.
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   flush                drop in-flight op and any held result
//   in_valid/in_ready    request handshake
//   in_op                0 ADD,1 SUB,2 AND,3 OR,4 SLT,5 MUL,6 RSUM,7 SADD
//   in_addr, in_mask     destination register, lane enables
//   in_a, in_b           operands, lane i at [i*DW +: DW]
//   out_valid/out_ready  result handshake
//   out_addr, out_mask   destination register, lane write enables
//   out_data, out_ovf    result lanes, per-lane signed overflow
//   busy                 multi-cycle op in progress
module vec_alu_pipe #(
  parameter int LANES = 8,
  parameter int DW    = 32,
  parameter int RW    = 5,
  parameter int LOG2L = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [2:0]            in_op,
  input  logic [RW-1:0]         in_addr,
  input  logic [LANES-1:0]      in_mask,
  input  logic [LANES*DW-1:0]   in_a,
  input  logic [LANES*DW-1:0]   in_b,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [RW-1:0]         out_addr,
  output logic [LANES-1:0]      out_mask,
  output logic [LANES*DW-1:0]   out_data,
  output logic [LANES-1:0]      out_ovf,
  output logic                  busy
);

  localparam int CW = $clog2(DW + 1);

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_SUB  = 3'd1;
  localparam logic [2:0] OP_AND  = 3'd2;
  localparam logic [2:0] OP_OR   = 3'd3;
  localparam logic [2:0] OP_SLT  = 3'd4;
  localparam logic [2:0] OP_MUL  = 3'd5;
  localparam logic [2:0] OP_RSUM = 3'd6;
  localparam logic [2:0] OP_SADD = 3'd7;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_RED  = 2'd2
  } state_t;

  state_t               r_state;
  logic [CW-1:0]        r_cnt;
  logic [RW-1:0]        r_addr;
  logic [LANES-1:0]     r_mask;
  logic [DW-1:0]        r_mcand  [LANES];
  logic [DW-1:0]        r_mplier [LANES];
  logic [DW-1:0]        r_acc    [LANES];

  logic                 w_accept;
  logic [LANES*DW-1:0]  w_sc_data;
  logic [LANES-1:0]     w_sc_ovf;
  logic [DW-1:0]        w_mul_next [LANES];
  logic [LANES*DW-1:0]  w_mul_vec;
  logic [DW-1:0]        w_red_next [LANES/2];
  logic                 w_mul_last;
  logic                 w_red_last;

  assign in_ready   = (r_state == S_IDLE) && (!out_valid || out_ready) && !flush;
  assign w_accept   = in_valid && in_ready;
  assign busy       = (r_state != S_IDLE);
  assign w_mul_last = (r_cnt == CW'(DW - 1));
  assign w_red_last = (r_cnt == CW'(LOG2L - 1));

  // Per-lane single-cycle datapath plus one shift-add step for MUL.
  for (genvar g = 0; g < LANES; g++) begin : g_lane
    logic [DW-1:0] w_a;
    logic [DW-1:0] w_b;
    logic [DW-1:0] w_bsel;
    logic [DW-1:0] w_add;
    logic [DW-1:0] w_sub;
    logic [DW-1:0] w_res;
    logic          w_ovf;

    assign w_a    = in_a[g*DW +: DW];
    assign w_b    = in_b[g*DW +: DW];
    // SADD broadcasts lane 0 of B into every lane.
    assign w_bsel = (in_op == OP_SADD) ? in_b[DW-1:0] : w_b;
    assign w_add  = w_a + w_bsel;
    assign w_sub  = w_a - w_b;

    always_comb begin
      w_res = '0;
      w_ovf = 1'b0;
      case (in_op)
        OP_ADD, OP_SADD: begin
          w_res = w_add;
          w_ovf = (w_a[DW-1] == w_bsel[DW-1]) && (w_add[DW-1] != w_a[DW-1]);
        end
        OP_SUB: begin
          w_res = w_sub;
          w_ovf = (w_a[DW-1] != w_b[DW-1]) && (w_sub[DW-1] != w_a[DW-1]);
        end
        OP_AND:  w_res = w_a & w_b;
        OP_OR:   w_res = w_a | w_b;
        OP_SLT:  w_res = {{(DW-1){1'b0}}, ($signed(w_a) < $signed(w_b))};
        default: begin
          w_res = '0;
          w_ovf = 1'b0;
        end
      endcase
      if (!in_mask[g]) begin
        w_res = '0;
        w_ovf = 1'b0;
      end
    end

    assign w_sc_data[g*DW +: DW] = w_res;
    assign w_sc_ovf[g]           = w_ovf;

    // Multiplicand shifts left and multiplier right each step, so bit 0 of
    // the multiplier always selects the current partial product.
    assign w_mul_next[g]         = r_acc[g] + (r_mplier[g][0] ? r_mcand[g] : '0);
    assign w_mul_vec[g*DW +: DW] = r_mask[g] ? w_mul_next[g] : '0;
  end

  // One adder-tree level per cycle, folded in place into the low half of r_acc.
  for (genvar g = 0; g < LANES/2; g++) begin : g_tree
    assign w_red_next[g] = r_acc[2*g] + r_acc[2*g+1];
  end

  // Operand / working registers: no reset, frozen by rst and flush.
  always_ff @(posedge clk) begin
    if (!rst && !flush) begin
      if (w_accept) begin
        r_addr <= in_addr;
        r_mask <= in_mask;
        for (int unsigned i = 0; i < LANES; i++) begin
          r_mcand[i]  <= in_a[i*DW +: DW];
          r_mplier[i] <= in_b[i*DW +: DW];
          r_acc[i]    <= ((in_op == OP_RSUM) && in_mask[i]) ? in_a[i*DW +: DW] : '0;
        end
      end else if (r_state == S_MUL) begin
        for (int unsigned i = 0; i < LANES; i++) begin
          r_acc[i]    <= w_mul_next[i];
          r_mcand[i]  <= r_mcand[i] << 1;
          r_mplier[i] <= r_mplier[i] >> 1;
        end
      end else if (r_state == S_RED) begin
        for (int unsigned i = 0; i < LANES/2; i++) begin
          r_acc[i] <= w_red_next[i];
        end
      end
    end
  end

  // Control and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      out_valid <= 1'b0;
      out_addr  <= '0;
      out_mask  <= '0;
      out_data  <= '0;
      out_ovf   <= '0;
    end else if (flush) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      out_valid <= 1'b0;
    end else begin
      // Default drop on acceptance; a completing op below overrides it.
      if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_cnt <= '0;
            if (in_op == OP_MUL) begin
              r_state <= S_MUL;
            end else if (in_op == OP_RSUM) begin
              r_state <= S_RED;
            end else begin
              out_valid <= 1'b1;
              out_addr  <= in_addr;
              out_mask  <= in_mask;
              out_data  <= w_sc_data;
              out_ovf   <= w_sc_ovf;
            end
          end
        end
        S_MUL: begin
          r_cnt <= r_cnt + 1'b1;
          if (w_mul_last) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            out_valid <= 1'b1;
            out_addr  <= r_addr;
            out_mask  <= r_mask;
            out_data  <= w_mul_vec;
            out_ovf   <= '0;
          end
        end
        S_RED: begin
          r_cnt <= r_cnt + 1'b1;
          if (w_red_last) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            out_valid <= 1'b1;
            out_addr  <= r_addr;
            out_mask  <= {{(LANES-1){1'b0}}, |r_mask};
            out_data  <= {{((LANES-1)*DW){1'b0}}, w_red_next[0]};
            out_ovf   <= '0;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vec_alu_pipe.sv
module tb_vec_alu_pipe;

  localparam int LANES = 8;
  localparam int DW    = 32;
  localparam int RW    = 5;
  localparam int LOG2L = 3;
  localparam int VW    = LANES * DW;

  typedef logic [VW-1:0] vec_t;

  typedef struct {
    string            name;
    logic [2:0]       op;
    logic [LANES-1:0] mask;
    vec_t             a;
    vec_t             b;
    vec_t             ed;
    logic [LANES-1:0] eo;
    logic [LANES-1:0] em;
  } tv_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       in_op;
  logic [RW-1:0]    in_addr;
  logic [LANES-1:0] in_mask;
  vec_t             in_a;
  vec_t             in_b;
  logic             out_valid;
  logic             out_ready;
  logic [RW-1:0]    out_addr;
  logic [LANES-1:0] out_mask;
  vec_t             out_data;
  logic [LANES-1:0] out_ovf;
  logic             busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  vec_alu_pipe #(
    .LANES(LANES),
    .DW   (DW),
    .RW   (RW),
    .LOG2L(LOG2L)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_op    (in_op),
    .in_addr  (in_addr),
    .in_mask  (in_mask),
    .in_a     (in_a),
    .in_b     (in_b),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_addr (out_addr),
    .out_mask (out_mask),
    .out_data (out_data),
    .out_ovf  (out_ovf),
    .busy     (busy)
  );

  task automatic chk(input string nm, input vec_t act, input vec_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic vec_t set_lane(input vec_t v, input int i, input logic [DW-1:0] x);
    vec_t r;
    r = v;
    r[i*DW +: DW] = x;
    return r;
  endfunction

  function automatic vec_t fill(input logic [DW-1:0] x);
    vec_t r;
    for (int i = 0; i < LANES; i++) r[i*DW +: DW] = x;
    return r;
  endfunction

  function automatic vec_t rand_vec();
    vec_t r;
    for (int i = 0; i < LANES; i++) begin
      case ($urandom_range(0, 4))
        0:       r[i*DW +: DW] = 32'h7FFF_FFFF;
        1:       r[i*DW +: DW] = 32'h8000_0000;
        2:       r[i*DW +: DW] = 32'($urandom_range(0, 20));
        default: r[i*DW +: DW] = 32'($urandom);
      endcase
    end
    return r;
  endfunction

  function automatic int exp_lat(input logic [2:0] op);
    if (op == 3'd5) return DW + 1;
    if (op == 3'd6) return LOG2L + 1;
    return 1;
  endfunction

  // Reference model: integer arithmetic on signed/unsigned lane values.
  function automatic void model(input logic [2:0] op, input logic [LANES-1:0] m,
                                input vec_t a, input vec_t b, output vec_t d,
                                output logic [LANES-1:0] o, output logic [LANES-1:0] om);
    longint unsigned modv = 64'd1 << DW;
    longint          maxs = longint'(modv / 2) - 1;
    longint          mins = -longint'(modv / 2);
    longint unsigned total = 0;
    d  = '0;
    o  = '0;
    om = m;
    for (int i = 0; i < LANES; i++) begin
      longint unsigned x = 64'(a[i*DW +: DW]);
      longint unsigned y = (op == 3'd7) ? 64'(b[DW-1:0]) : 64'(b[i*DW +: DW]);
      longint sx = (x >= modv / 2) ? longint'(x) - longint'(modv) : longint'(x);
      longint sy = (y >= modv / 2) ? longint'(y) - longint'(modv) : longint'(y);
      longint unsigned r = 0;
      logic v = 1'b0;
      case (op)
        3'd0, 3'd7: begin r = longint'(sx + sy); v = (sx + sy > maxs) || (sx + sy < mins); end
        3'd1:       begin r = longint'(sx - sy); v = (sx - sy > maxs) || (sx - sy < mins); end
        3'd2:       r = x & y;
        3'd3:       r = x | y;
        3'd4:       r = (sx < sy) ? 1 : 0;
        3'd5:       r = x * y;
        default:    r = 0;
      endcase
      if (m[i]) begin
        d[i*DW +: DW] = r[DW-1:0];
        o[i]          = v;
        total         = total + x;
      end
    end
    if (op == 3'd6) begin
      d             = '0;
      d[DW-1:0]     = total[DW-1:0];
      o             = '0;
      om            = '0;
      om[0]         = |m;
    end
  endfunction

  task automatic run_op(input string nm, input logic [2:0] op, input logic [RW-1:0] addr,
                        input logic [LANES-1:0] m, input vec_t a, input vec_t b,
                        input vec_t ed, input logic [LANES-1:0] eo, input logic [LANES-1:0] em);
    int   n;
    int   lat;
    int   bcnt;
    int   rbad;
    int   hold;
    vec_t snap;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL %s.accept: in_ready=0 expected 1 within 200 cycles", nm);
      return;
    end
    in_valid  = 1'b1;
    in_op     = op;
    in_addr   = addr;
    in_mask   = m;
    in_a      = a;
    in_b      = b;
    out_ready = 1'b0;
    @(negedge clk);
    // Junk request held during the op must be ignored.
    in_op   = 3'($urandom);
    in_addr = RW'($urandom);
    in_mask = LANES'($urandom);
    in_a    = rand_vec();
    in_b    = rand_vec();
    lat  = 1;
    bcnt = 0;
    rbad = 0;
    while (!out_valid && lat < 200) begin
      if (busy) bcnt++;
      if (in_ready) rbad++;
      @(negedge clk);
      lat++;
    end
    in_valid = 1'b0;
    chk({nm, ".latency"}, vec_t'(lat), vec_t'(exp_lat(op)));
    chk({nm, ".busy_cycles"}, vec_t'(bcnt), vec_t'(exp_lat(op) - 1));
    chk({nm, ".ready_while_busy"}, vec_t'(rbad), '0);
    chk({nm, ".data"}, out_data, ed);
    chk({nm, ".ovf"}, vec_t'(out_ovf), vec_t'(eo));
    chk({nm, ".mask"}, vec_t'(out_mask), vec_t'(em));
    chk({nm, ".addr"}, vec_t'(out_addr), vec_t'(addr));
    snap = out_data;
    hold = $urandom_range(0, 2);
    repeat (hold) begin
      @(negedge clk);
      chk({nm, ".hold_valid"}, vec_t'(out_valid), vec_t'(1));
      chk({nm, ".hold_data"}, out_data, snap);
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk({nm, ".drop_valid"}, vec_t'(out_valid), '0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
    $fatal(1, "watchdog");
  end

  initial begin
    tv_t              tv[$];
    tv_t              t;
    vec_t             ed;
    vec_t             snap;
    logic [LANES-1:0] eo;
    logic [LANES-1:0] em;
    logic [2:0]       op;
    logic [LANES-1:0] m;
    vec_t             a;
    vec_t             b;
    int               cnt;

    // Directed vectors with hand-derived expectations.
    t.name = "add_ovf"; t.op = 3'd0; t.mask = 8'hFF;
    t.a = set_lane(set_lane('0, 0, 32'h7FFF_FFFF), 1, 32'd5);
    t.b = set_lane(set_lane('0, 0, 32'd1), 1, 32'd3);
    t.ed = set_lane(set_lane('0, 0, 32'h8000_0000), 1, 32'd8);
    t.eo = 8'h01; t.em = 8'hFF; tv.push_back(t);

    t.name = "mul_full"; t.op = 3'd5; t.mask = 8'hFF;
    t.a = fill(32'h0000_FFFF); t.b = fill(32'h0001_0001);
    t.ed = fill(32'hFFFF_FFFF); t.eo = 8'h00; t.em = 8'hFF; tv.push_back(t);

    t.name = "mul_masked"; t.op = 3'd5; t.mask = 8'h0F;
    t.a = fill(32'd3); t.b = fill(32'd7); t.ed = '0;
    for (int i = 0; i < 4; i++) t.ed = set_lane(t.ed, i, 32'd21);
    t.eo = 8'h00; t.em = 8'h0F; tv.push_back(t);

    t.a = '0;
    for (int i = 0; i < LANES; i++) t.a = set_lane(t.a, i, 32'(i + 1));
    t.name = "rsum_ff"; t.op = 3'd6; t.mask = 8'hFF; t.b = fill(32'hDEAD_BEEF);
    t.ed = set_lane('0, 0, 32'd36); t.eo = 8'h00; t.em = 8'h01; tv.push_back(t);
    t.name = "rsum_0f"; t.mask = 8'h0F; t.ed = set_lane('0, 0, 32'd10); tv.push_back(t);
    t.name = "rsum_00"; t.mask = 8'h00; t.ed = '0; t.em = 8'h00; tv.push_back(t);

    t.name = "slt_aa"; t.op = 3'd4; t.mask = 8'hAA;
    t.a = fill(32'hFFFF_FFFF); t.b = '0; t.ed = '0;
    for (int i = 1; i < LANES; i += 2) t.ed = set_lane(t.ed, i, 32'd1);
    t.eo = 8'h00; t.em = 8'hAA; tv.push_back(t);

    t.name = "sub_ovf"; t.op = 3'd1; t.mask = 8'hFF;
    t.a = set_lane(set_lane('0, 0, 32'h8000_0000), 1, 32'd9);
    t.b = set_lane(set_lane('0, 0, 32'd1), 1, 32'd4);
    t.ed = set_lane(set_lane('0, 0, 32'h7FFF_FFFF), 1, 32'd5);
    t.eo = 8'h01; t.em = 8'hFF; tv.push_back(t);

    t.name = "sadd_bcast"; t.op = 3'd7; t.mask = 8'h7F;
    t.a = '0; t.ed = '0; t.b = fill(32'h0000_DEAD); t.b = set_lane(t.b, 0, 32'd100);
    for (int i = 0; i < LANES; i++) begin
      t.a = set_lane(t.a, i, 32'(i * 16));
      if (i < 7) t.ed = set_lane(t.ed, i, 32'(i * 16 + 100));
    end
    t.a = set_lane(t.a, 7, 32'h7FFF_FFFF);
    t.eo = 8'h00; t.em = 8'h7F; tv.push_back(t);

    t.name = "and"; t.op = 3'd2; t.mask = 8'hFF;
    t.a = fill(32'hF0F0_F0F0); t.b = fill(32'hFF00_FF00);
    t.ed = fill(32'hF000_F000); t.eo = 8'h00; t.em = 8'hFF; tv.push_back(t);
    t.name = "or"; t.op = 3'd3; t.ed = fill(32'hFFF0_FFF0); tv.push_back(t);

    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_op = '0; in_addr = '0;
    in_mask = '0; in_a = '0; in_b = '0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset.out_valid", vec_t'(out_valid), '0);
    chk("reset.out_data", out_data, '0);
    chk("reset.out_mask", vec_t'(out_mask), '0);
    chk("reset.out_ovf", vec_t'(out_ovf), '0);
    chk("reset.out_addr", vec_t'(out_addr), '0);
    chk("reset.busy", vec_t'(busy), '0);
    rst = 1'b0;
    #1;
    chk("reset.in_ready", vec_t'(in_ready), vec_t'(1));

    foreach (tv[k]) begin
      run_op(tv[k].name, tv[k].op, RW'(k + 1), tv[k].mask, tv[k].a, tv[k].b,
             tv[k].ed, tv[k].eo, tv[k].em);
    end

    // Back-pressure: result A held while request B waits, then both move on one edge.
    a = '0;
    for (int i = 0; i < LANES; i++) a = set_lane(a, i, 32'(i + 1));
    @(negedge clk);
    out_ready = 1'b0;
    in_valid = 1'b1; in_op = 3'd0; in_addr = 5'd3; in_mask = 8'hFF; in_a = a; in_b = fill(32'd10);
    @(negedge clk);
    model(3'd0, 8'hFF, a, fill(32'd10), ed, eo, em);
    in_op = 3'd0; in_addr = 5'd4; in_mask = 8'hFF; in_a = fill(32'd100); in_b = a;
    chk("bp.valid", vec_t'(out_valid), vec_t'(1));
    chk("bp.data_a", out_data, ed);
    snap = out_data;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("bp.in_ready_low", vec_t'(in_ready), '0);
      chk("bp.stable_data", out_data, snap);
      chk("bp.stable_addr", vec_t'(out_addr), vec_t'(3));
      chk("bp.stable_valid", vec_t'(out_valid), vec_t'(1));
    end
    out_ready = 1'b1;
    #1;
    chk("bp.in_ready_same_cycle", vec_t'(in_ready), vec_t'(1));
    @(negedge clk);
    in_valid = 1'b0;
    model(3'd0, 8'hFF, fill(32'd100), a, ed, eo, em);
    chk("bp.next_valid", vec_t'(out_valid), vec_t'(1));
    chk("bp.data_b", out_data, ed);
    chk("bp.addr_b", vec_t'(out_addr), vec_t'(4));
    @(negedge clk);
    chk("bp.drop", vec_t'(out_valid), '0);

    // Flush 10 cycles into a MUL; a request offered with the flush is refused.
    in_valid = 1'b1; in_op = 3'd5; in_addr = 5'd9; in_mask = 8'hFF;
    in_a = fill(32'd7); in_b = fill(32'd6);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (9) @(negedge clk);
    chk("flush.busy_before", vec_t'(busy), vec_t'(1));
    flush = 1'b1;
    in_valid = 1'b1; in_op = 3'd0; in_a = fill(32'd1); in_b = fill(32'd1);
    #1;
    chk("flush.in_ready_low", vec_t'(in_ready), '0);
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    #1;
    chk("flush.busy", vec_t'(busy), '0);
    chk("flush.out_valid", vec_t'(out_valid), '0);
    chk("flush.in_ready", vec_t'(in_ready), vec_t'(1));
    cnt = 0;
    repeat (DW + 5) begin
      @(negedge clk);
      if (out_valid) cnt++;
    end
    chk("flush.no_result", vec_t'(cnt), '0);
    run_op("flush.sub_after", 3'd1, 5'd10, 8'hFF, fill(32'd9), fill(32'd4),
           fill(32'd5), 8'h00, 8'hFF);

    // Reset in the middle of a reduction clears every output.
    @(negedge clk);
    in_valid = 1'b1; in_op = 3'd6; in_addr = 5'd12; in_mask = 8'hFF; in_a = a;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    chk("rstred.busy_before", vec_t'(busy), vec_t'(1));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rstred.out_data", out_data, '0);
    chk("rstred.out_mask", vec_t'(out_mask), '0);
    chk("rstred.out_ovf", vec_t'(out_ovf), '0);
    chk("rstred.out_addr", vec_t'(out_addr), '0);
    chk("rstred.out_valid", vec_t'(out_valid), '0);
    chk("rstred.busy", vec_t'(busy), '0);
    cnt = 0;
    repeat (8) begin
      @(negedge clk);
      if (out_valid) cnt++;
    end
    chk("rstred.no_result", vec_t'(cnt), '0);

    // Randomised ops against the reference model.
    for (int r = 0; r < 40; r++) begin
      op = 3'($urandom_range(0, 7));
      m  = ($urandom_range(0, 3) == 0) ? 8'hFF : LANES'($urandom);
      a  = rand_vec();
      b  = rand_vec();
      model(op, m, a, b, ed, eo, em);
      run_op($sformatf("rand%0d_op%0d", r, op), op, RW'($urandom), m, a, b, ed, eo, em);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vec_alu_pipe.md
Name: vec_alu_pipe

Overview:
- Parametrised N-lane vector execute unit; successor to the fixed 8-lane, 32-bit EXE stage. Sits between ID/EXE and EX/MEM.
- Adds valid/ready handshakes on both sides and per-lane write masks.
- Adds two multi-cycle ops: an iterative lane-parallel multiply and a lane-reduction sum.
- Adds a synchronous flush input used for branch squash.

Parameters:
LANES, 8, lane count; power of two, minimum 2
DW, 32, lane data width in bits
RW, 5, destination register address width
LOG2L, 3, log2(LANES); must be consistent with LANES

Ports:
clk  in  1  clock; all logic samples on the rising edge
rst  in  1  reset, synchronous, active-high
flush  in  1  abort the in-flight op and drop any held result
in_valid  in  1  request valid
in_ready  out  1  unit can accept a request this cycle
in_op  in  3  0 ADD, 1 SUB, 2 AND, 3 OR, 4 SLT (signed), 5 MUL, 6 RSUM, 7 SADD (lane a + b lane0 broadcast)
in_addr  in  RW  destination vector register
in_mask  in  LANES  lane enable; bit i maps to lane i
in_a  in  LANES*DW  operand A; lane i occupies bits [i*DW +: DW]
in_b  in  LANES*DW  operand B; same lane packing as in_a
out_valid  out  1  result valid
out_ready  in  1  downstream accepts the result
out_addr  out  RW  destination address, carried from the request
out_mask  out  LANES  lane write enables
out_data  out  LANES*DW  result lanes
out_ovf  out  LANES  per-lane signed overflow
busy  out  1  multi-cycle op in progress

Behaviour:
- Reset (rst=1 at a clock edge): state=IDLE; out_valid=0; out_data=0; out_addr=0; out_mask=0; out_ovf=0; busy=0; counter=0.
- in_ready = (state==IDLE) && (!out_valid || out_ready) && !flush. This is combinational; an accepted result and a new request may complete in the same cycle.
- A request is accepted when in_valid && in_ready at the clock edge (cycle T). Operands, op, addr and mask are captured into internal registers.
- State machine: IDLE, MUL, RED.
  - Ops 0-4 and 7 stay in IDLE. out_valid rises at T+1.
  - MUL: IDLE->MUL at T. Shift-add loop runs one multiplier bit per cycle, all lanes in parallel, for DW cycles. Then MUL->IDLE and out_valid rises at T+DW+1.
  - RSUM: IDLE->RED at T. One adder-tree level per cycle for LOG2L cycles. Then RED->IDLE and out_valid rises at T+LOG2L+1.
  - busy=1 while state is MUL or RED.
- Arithmetic wraps modulo 2^DW.
  - ADD/SUB/SADD: out_ovf[i] = signed overflow of lane i.
  - SLT: lane result is 1 if a<b signed, else 0.
  - MUL: low DW bits of the product; ovf=0.
  - AND/OR: ovf=0.
- Masking for element-wise ops:
  - Lanes with mask=0 output data 0 and ovf 0.
  - out_mask = captured in_mask.
- Masking and layout for RSUM:
  - Masked-off lanes contribute 0 to the sum.
  - Lane0 = wrapped sum; all other lanes 0.
  - out_mask = 1 in bit 0 only, or all zero if in_mask==0.
  - ovf all 0.
- Holding the result:
  - out_* stay stable while out_valid && !out_ready.
  - out_valid drops on the cycle after acceptance unless a new result loads the same edge.
  - A multi-cycle op never completes while an unaccepted result is held, because in_ready gates acceptance.
- flush (priority below rst, above everything else):
  - Next edge: state=IDLE, out_valid=0, counter=0.
  - Data registers keep their values; the old result is not visible since out_valid=0.
  - A request offered in the flush cycle is not accepted (in_ready=0).
- Reset or flush mid-MUL/RED: the operation is discarded. No out_valid ever appears for it.
- in_op is sampled only at acceptance. Changes to in_* during MUL/RED have no effect.

Test Plan:
1. Single-cycle ADD, full mask, DW=32, all out_ready=1. Lane0 a=0x7FFFFFFF, b=1; lane1 a=5, b=3. Expected: out_valid at T+1; lane0=0x80000000 with ovf[0]=1; lane1=8 with ovf[1]=0.
2. MUL, full mask, ready=1. All lanes a=0xFFFF, b=0x10001. Expected: busy for 32 cycles; out_valid at T+33; every lane=0xFFFFFFFF; in_ready=0 throughout.
3. RSUM, LANES=8, a lanes = 1..8, mask=0xFF then mask=0x0F. Expected: first request lane0=36, other lanes 0, out_mask=0x01, out_valid at T+4; second request lane0=10.
4. Back-pressure: ADD result with out_ready=0 for 5 cycles while in_valid stays high. Expected: out_* constant and in_ready=0; when out_ready=1, the next request is accepted that same cycle and its result appears the following cycle.
5. Flush asserted 10 cycles into a MUL. Expected: next cycle state IDLE, busy=0, out_valid=0; no result ever emerges; a following SUB 9-4 returns lane=5.
6. Mask 0xAA with SLT, a=-1, b=0 in all lanes. Expected: odd lanes=1, even lanes=0, out_mask=0xAA. rst asserted mid-RED: all outputs return to 0 at the next edge.
